dbi_frame_sequencer: RTL and testbench

Frame-level controller for the DBI TX path. On each frame request it emits the DBI Type-C window setup command stream (CASET, PASET, RAMWR with parameters), then passes exactly one frame of RGB565 pixel bytes from the gray-to-RGB converter through to the DBI TX byte interface. It owns the D/CX line and gates the converter's ready, so pixel bytes move only during the pixel phase.

---
 rtl/dbi_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dbi_frame_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbi_frame_sequencer.sv
// DBI Type-C frame sequencer: emits window setup commands, then forwards one frame of RGB565 bytes.
// Optional DBI_SEQ_COLMOD_EN prepends COLMOD 0x3A / 0x55 to every frame's setup stream.
module dbi_frame_sequencer #(
    parameter int IMG_W = 240,
    parameter int IMG_H = 320,
    parameter int DAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start_i,
    input  logic [DAT_W-1:0] pxl_dat_i,
    input  logic             pxl_vld_i,
    output logic             pxl_rdy_o,
    output logic [DAT_W-1:0] dbi_dat_o,
    output logic             dbi_dcx_o,
    output logic             dbi_vld_o,
    input  logic             dbi_rdy_i,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam longint unsigned PIX_BYTES = 64'(2) * 64'(IMG_W) * 64'(IMG_H);
    localparam int CNT_W = $clog2(PIX_BYTES);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_BYTES - 64'(1));
    localparam logic [15:0] W_M1 = 16'(IMG_W - 1);
    localparam logic [15:0] H_M1 = 16'(IMG_H - 1);

    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] PAR_COLMOD = 8'h55;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef DBI_SEQ_COLMOD_EN
        S_COLMOD_CMD,
        S_COLMOD_PAR,
`endif
        S_CASET_CMD,
        S_CASET_PAR,
        S_PASET_CMD,
        S_PASET_PAR,
        S_RAMWR_CMD,
        S_PIXEL,
        S_DONE
    } state_t;

`ifdef DBI_SEQ_COLMOD_EN
    localparam state_t FIRST_CMD = S_COLMOD_CMD;
`else
    localparam state_t FIRST_CMD = S_CASET_CMD;
`endif

    state_t           state, state_nxt;
    logic [1:0]       par_idx, par_idx_nxt;
    logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;

    // Window parameters: start address is always 0, end address big-endian.
    function automatic logic [7:0] par_byte(input logic [1:0] idx, input logic [15:0] v);
        case (idx)
            2'd2:    return v[15:8];
            2'd3:    return v[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            par_idx <= '0;
            pix_cnt <= '0;
        end else begin
            state   <= state_nxt;
            par_idx <= par_idx_nxt;
            pix_cnt <= pix_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        par_idx_nxt = par_idx;
        pix_cnt_nxt = pix_cnt;
        dbi_dat_o   = '0;
        dbi_dcx_o   = 1'b0;
        dbi_vld_o   = 1'b0;
        pxl_rdy_o   = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start_i) state_nxt = FIRST_CMD;
            end
`ifdef DBI_SEQ_COLMOD_EN
            S_COLMOD_CMD: begin
                dbi_dat_o = DAT_W'(CMD_COLMOD);
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) state_nxt = S_COLMOD_PAR;
            end
            S_COLMOD_PAR: begin
                dbi_dat_o = DAT_W'(PAR_COLMOD);
                dbi_dcx_o = 1'b1;
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) state_nxt = S_CASET_CMD;
            end
`endif
            S_CASET_CMD: begin
                dbi_dat_o = DAT_W'(CMD_CASET);
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) state_nxt = S_CASET_PAR;
            end
            S_CASET_PAR: begin
                dbi_dat_o = DAT_W'(par_byte(par_idx, W_M1));
                dbi_dcx_o = 1'b1;
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) begin
                    par_idx_nxt = par_idx + 2'd1;
                    if (par_idx == 2'd3) state_nxt = S_PASET_CMD;
                end
            end
            S_PASET_CMD: begin
                dbi_dat_o = DAT_W'(CMD_PASET);
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) state_nxt = S_PASET_PAR;
            end
            S_PASET_PAR: begin
                dbi_dat_o = DAT_W'(par_byte(par_idx, H_M1));
                dbi_dcx_o = 1'b1;
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) begin
                    par_idx_nxt = par_idx + 2'd1;
                    if (par_idx == 2'd3) state_nxt = S_RAMWR_CMD;
                end
            end
            S_RAMWR_CMD: begin
                dbi_dat_o = DAT_W'(CMD_RAMWR);
                dbi_vld_o = 1'b1;
                if (dbi_rdy_i) state_nxt = S_PIXEL;
            end
            S_PIXEL: begin
                // Pass-through: the converter sees TX backpressure directly.
                dbi_dat_o = pxl_dat_i;
                dbi_dcx_o = 1'b1;
                dbi_vld_o = pxl_vld_i;
                pxl_rdy_o = dbi_rdy_i;
                if (pxl_vld_i && dbi_rdy_i) begin
                    if (pix_cnt == PIX_LAST) begin
                        pix_cnt_nxt = '0;
                        state_nxt   = S_DONE;
                    end else begin
                        pix_cnt_nxt = pix_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy_o       = (state != S_IDLE);
    assign frame_done_o = (state == S_DONE);

endmodule

// File: tb/tb_dbi_frame_sequencer.sv
// Directed bench for dbi_frame_sequencer on a 4x2 image: setup stream, pixel pass-through, stalls, restarts, reset.
module tb_dbi_frame_sequencer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int PIX = 2 * W * H;
`ifdef DBI_SEQ_COLMOD_EN
    localparam int SETUP = 13;
`else
    localparam int SETUP = 11;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start_i;
    logic [7:0] pxl_dat_i;
    logic       pxl_vld_i;
    logic       pxl_rdy_o;
    logic [7:0] dbi_dat_o;
    logic       dbi_dcx_o;
    logic       dbi_vld_o;
    logic       dbi_rdy_i;
    logic       busy_o;
    logic       frame_done_o;

    dbi_frame_sequencer #(.IMG_W(W), .IMG_H(H), .DAT_W(8)) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start_i),
        .pxl_dat_i(pxl_dat_i), .pxl_vld_i(pxl_vld_i), .pxl_rdy_o(pxl_rdy_o),
        .dbi_dat_o(dbi_dat_o), .dbi_dcx_o(dbi_dcx_o), .dbi_vld_o(dbi_vld_o),
        .dbi_rdy_i(dbi_rdy_i), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dat;
        logic       dcx;
    } dbyte_t;

    typedef struct {
        int rdy_mode;   // 0: dbi_rdy_i held high, 1: random stalls
        int vld_mode;   // 0: pxl_vld_i held high, 1: valid every other cycle
        int inject;     // extra frame_start pulses inside the frame
        int exp_cyc;    // expected start->done distance, -1 when stalls make it variable
    } scen_t;

    dbyte_t     cap[$];
    dbyte_t     setup_tbl[SETUP];
    scen_t      scen[5];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    int         rdy_mode = 0;
    int         vld_mode = 0;
    logic       pxl_take = 1'b0;
    logic       vld_tog = 1'b0;
    logic [7:0] pix_val;
    logic [7:0] pix_at_start;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat = '0;
    logic       prev_dcx = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture handshakes, check stall stability and converter gating during setup.
    always @(negedge clk) begin
        pxl_take = pxl_vld_i & pxl_rdy_o;
        if (!rst) begin
            if (prev_stall) begin
                check("stall_vld", 64'(dbi_vld_o), 64'(1));
                check("stall_dat", 64'(dbi_dat_o), 64'(prev_dat));
                check("stall_dcx", 64'(dbi_dcx_o), 64'(prev_dcx));
            end
            if (cap.size() < SETUP) check("pxl_rdy_in_setup", 64'(pxl_rdy_o), 64'(0));
            if (frame_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = dbi_vld_o & ~dbi_rdy_i & (cap.size() < SETUP);
            prev_dat   = dbi_dat_o;
            prev_dcx   = dbi_dcx_o;
            if (dbi_vld_o && dbi_rdy_i) cap.push_back({dbi_dat_o, dbi_dcx_o});
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pxl_take) pix_val = pix_val + 8'd1;
        frame_start_i = 1'b0;
        dbi_rdy_i = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        vld_tog = ~vld_tog;
        pxl_vld_i = (vld_mode == 0) ? 1'b1 : vld_tog;
        pxl_dat_i = pix_val;
    endtask

    task automatic start_frame();
        cap.delete();
        done_cnt = 0;
        frame_start_i = 1'b1;
        start_cyc = cyc;
        pix_at_start = pix_val;
    endtask

    task automatic check_capture(input string tag);
        check({tag, "_len"}, 64'(cap.size()), 64'(SETUP + PIX));
        for (int i = 0; i < SETUP && i < cap.size(); i++) begin
            check($sformatf("%s_setup%0d_dat", tag, i), 64'(cap[i].dat), 64'(setup_tbl[i].dat));
            check($sformatf("%s_setup%0d_dcx", tag, i), 64'(cap[i].dcx), 64'(setup_tbl[i].dcx));
        end
        for (int k = 0; k < PIX && SETUP + k < cap.size(); k++) begin
            logic [7:0] e;
            e = pix_at_start + 8'(k);
            check($sformatf("%s_pix%0d_dat", tag, k), 64'(cap[SETUP+k].dat), 64'(e));
            check($sformatf("%s_pix%0d_dcx", tag, k), 64'(cap[SETUP+k].dcx), 64'(1));
        end
    endtask

    task automatic run_scen(input scen_t s, input string tag);
        int n;
        bit inj1, inj2;
        inj1 = 0;
        inj2 = 0;
        rdy_mode = s.rdy_mode;
        vld_mode = s.vld_mode;
        step();
        start_frame();
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            step();
            n++;
            if (s.inject != 0) begin
                if (!inj1 && cap.size() == SETUP - 3) begin
                    frame_start_i = 1'b1;  // lands in PASET_PAR
                    inj1 = 1;
                end else if (!inj2 && cap.size() == SETUP + 5) begin
                    frame_start_i = 1'b1;  // lands in PIXEL
                    inj2 = 1;
                end
            end
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 64'(0), 64'(1));
        if (s.exp_cyc > 0) check({tag, "_done_cycle"}, 64'(done_cyc - start_cyc), 64'(s.exp_cyc));
        repeat (4) step();
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({tag, "_idle_busy"}, 64'(busy_o), 64'(0));
        check({tag, "_idle_vld"}, 64'(dbi_vld_o), 64'(0));
        check_capture(tag);
    endtask

    initial begin
        int k;
        logic [15:0] wm1, hm1;
        wm1 = 16'(W - 1);
        hm1 = 16'(H - 1);
        k = 0;
`ifdef DBI_SEQ_COLMOD_EN
        setup_tbl[0] = {8'h3A, 1'b0};
        setup_tbl[1] = {8'h55, 1'b1};
        k = 2;
`endif
        setup_tbl[k+0]  = {8'h2A, 1'b0};
        setup_tbl[k+1]  = {8'h00, 1'b1};
        setup_tbl[k+2]  = {8'h00, 1'b1};
        setup_tbl[k+3]  = {wm1[15:8], 1'b1};
        setup_tbl[k+4]  = {wm1[7:0], 1'b1};
        setup_tbl[k+5]  = {8'h2B, 1'b0};
        setup_tbl[k+6]  = {8'h00, 1'b1};
        setup_tbl[k+7]  = {8'h00, 1'b1};
        setup_tbl[k+8]  = {hm1[15:8], 1'b1};
        setup_tbl[k+9]  = {hm1[7:0], 1'b1};
        setup_tbl[k+10] = {8'h2C, 1'b0};

        scen[0] = '{rdy_mode: 0, vld_mode: 0, inject: 0, exp_cyc: SETUP + PIX + 1};
        scen[1] = '{rdy_mode: 1, vld_mode: 0, inject: 0, exp_cyc: -1};
        scen[2] = '{rdy_mode: 0, vld_mode: 1, inject: 0, exp_cyc: -1};
        scen[3] = '{rdy_mode: 1, vld_mode: 1, inject: 0, exp_cyc: -1};
        scen[4] = '{rdy_mode: 0, vld_mode: 0, inject: 1, exp_cyc: SETUP + PIX + 1};

        rst = 1'b1;
        frame_start_i = 1'b0;
        dbi_rdy_i = 1'b1;
        pxl_vld_i = 1'b1;
        pix_val = 8'h10;
        pxl_dat_i = pix_val;
        repeat (3) step();
        check("rst_dat", 64'(dbi_dat_o), 64'(0));
        check("rst_dcx", 64'(dbi_dcx_o), 64'(0));
        check("rst_vld", 64'(dbi_vld_o), 64'(0));
        check("rst_pxl_rdy", 64'(pxl_rdy_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(frame_done_o), 64'(0));
        // Reset must win over a simultaneous frame request.
        frame_start_i = 1'b1;
        step();
        check("rst_beats_start", 64'(busy_o), 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_scen(scen[i], $sformatf("scen%0d", i));

        // Reset while the sixth pixel byte is on the bus.
        rdy_mode = 0;
        vld_mode = 0;
        step();
        start_frame();
        for (int n = 0; n < 200 && cap.size() < SETUP + 5; n++) step();
        check("rst_mid_reached", 64'(cap.size()), 64'(SETUP + 5));
        rst = 1'b1;
        step();
        check("midrst_dat", 64'(dbi_dat_o), 64'(0));
        check("midrst_dcx", 64'(dbi_dcx_o), 64'(0));
        check("midrst_vld", 64'(dbi_vld_o), 64'(0));
        check("midrst_pxl_rdy", 64'(pxl_rdy_o), 64'(0));
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_done", 64'(frame_done_o), 64'(0));
        rst = 1'b0;
        repeat (5) step();
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        run_scen(scen[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
